icache_dm_rv32: RTL and testbench

ICACHE_DM_RV32 -- requirements
Module: icache_dm_rv32

---
 rtl/rv32_cache_pkg.sv | 9 +
 rtl/cache_tag_ram.sv | 33 +++
 rtl/icache_dm_rv32.sv | 88 ++++++++
 tb/tb_icache_dm_rv32.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_cache_pkg.sv
// rv32_cache_pkg: shared FSM encoding, default geometry and address-field helper
package rv32_cache_pkg;
    typedef enum logic [1:0] {IDLE, REFILL, FILLED} state_t;
    localparam int DEF_LINES = 16;
    localparam int DEF_WPL   = 4;
    function automatic int tag_bits(input int lines, input int wpl);
        return 32 - $clog2(lines) - $clog2(wpl) - 2;
    endfunction
endpackage

// File: rtl/cache_tag_ram.sv
// cache_tag_ram: valid+tag array with per-line write and single-cycle flash clear
module cache_tag_ram #(
    parameter int LINES = 16,
    parameter int TAGW  = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(LINES)-1:0] rd_idx,
    output logic                     rd_valid,
    output logic [TAGW-1:0]          rd_tag,
    input  logic                     wr_en,
    input  logic [$clog2(LINES)-1:0] wr_idx,
    input  logic                     wr_valid,
    input  logic [TAGW-1:0]          wr_tag,
    input  logic                     clr
);
    logic [LINES-1:0] valid;
    logic [TAGW-1:0]  tags [LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];

    // valid bits: reset and flash clear win over a single-line write
    always_ff @(posedge clk) begin
        if (!rst_n || clr) valid <= '0;
        else if (wr_en) valid[wr_idx] <= wr_valid;
    end

    // tags are only meaningful behind a set valid bit, so they carry no reset
    always_ff @(posedge clk) begin
        if (wr_en) tags[wr_idx] <= wr_tag;
    end
endmodule

// File: rtl/icache_dm_rv32.sv
// icache_dm_rv32: direct-mapped RV32 instruction cache with a word-by-word line refill
module icache_dm_rv32
    import rv32_cache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WPL   = DEF_WPL
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic        iREQ,
    input  logic [31:0] iINSTADDR,
    input  logic        iFLUSH,
    output logic [31:0] oINSTDATA,
    output logic        oStallI,
    output logic        oMEMREQ,
    output logic [31:0] oMEMADDR,
    input  logic [31:0] iMEMDATA,
    input  logic        iMEMVALID
);
    localparam int OFFW = $clog2(WPL);
    localparam int IDXW = $clog2(LINES);
    localparam int TAGW = tag_bits(LINES, WPL);

    state_t           state, state_nx;
    logic [OFFW-1:0]  off, beat;
    logic [IDXW-1:0]  idx;
    logic [TAGW-1:0]  tag, rd_tag;
    logic [29-OFFW:0] line_addr;
    logic             rd_valid, hit, miss, filled, mem_beat, flush_pend, unused_bits;
    logic [31:0]      data [LINES][WPL];

    assign off         = iINSTADDR[OFFW+1:2];
    assign idx         = iINSTADDR[IDXW+OFFW+1:OFFW+2];
    assign tag         = iINSTADDR[31:IDXW+OFFW+2];
    assign unused_bits = ^iINSTADDR[1:0];
    assign filled      = state == FILLED;
    assign mem_beat    = oMEMREQ & iMEMVALID;
    assign oMEMADDR    = {line_addr, beat, 2'b00};

    // miss invalidates the target line; FILLED validates it; a flush clears every line
    cache_tag_ram #(.LINES(LINES), .TAGW(TAGW)) u_tags (
        .clk     (iCLK),
        .rst_n   (iRSTn),
        .rd_idx  (idx),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .wr_en   (miss | filled),
        .wr_idx  (filled ? line_addr[IDXW-1:0] : idx),
        .wr_valid(filled),
        .wr_tag  (line_addr[29-OFFW:IDXW]),
        .clr     ((iFLUSH & (state == IDLE)) | (filled & (flush_pend | iFLUSH)))
    );

    // lookup, stall/memory-request outputs and next state; a flushing lookup never hits
    always_comb begin
        hit      = iREQ & ~iFLUSH & (state == IDLE) & rd_valid & (rd_tag == tag);
        miss     = iREQ & ~hit & (state == IDLE);
        oStallI  = (iREQ & ~hit) | (state != IDLE);
        oMEMREQ  = state == REFILL;
        state_nx = miss ? REFILL : (state == REFILL) ? ((oMEMREQ & iMEMVALID & (&beat)) ? FILLED : REFILL) : IDLE;
    end

    // state, refill line/beat, deferred flush and the registered fetch word
    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state      <= IDLE;
            line_addr  <= '0;
            beat       <= '0;
            flush_pend <= 1'b0;
            oINSTDATA  <= '0;
        end else begin
            state      <= state_nx;
            flush_pend <= (state == REFILL) & (flush_pend | iFLUSH);
            if (miss) begin
                line_addr <= iINSTADDR[31:OFFW+2];
                beat      <= '0;
            end else if (mem_beat) begin
                beat <= beat + 1'b1;
            end
            if (hit) oINSTDATA <= data[idx][off];
        end
    end

    // line data is written beat by beat and needs no reset
    always_ff @(posedge iCLK) begin
        if (mem_beat) data[line_addr[IDXW-1:0]][beat] <= iMEMDATA;
    end
endmodule

// File: tb/tb_icache_dm_rv32.sv
// tb_icache_dm_rv32: directed fetch scenarios checked through data and memory-address scoreboards
module tb_icache_dm_rv32;
    localparam int MW = 2;

    logic        iCLK, iRSTn, iREQ, iFLUSH, oStallI, oMEMREQ, iMEMVALID;
    logic [31:0] iINSTADDR, oINSTDATA, oMEMADDR, iMEMDATA;
    logic [31:0] exp_data[$], exp_addr[$];
    logic [31:0] mon_e;
    bit          fire_q, mem_hold = 0, spurious = 0;
    int          checks = 0, failures = 0;

    icache_dm_rv32 #(.LINES(16), .WPL(4)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iREQ(iREQ), .iINSTADDR(iINSTADDR), .iFLUSH(iFLUSH),
        .oINSTDATA(oINSTDATA), .oStallI(oStallI), .oMEMREQ(oMEMREQ), .oMEMADDR(oMEMADDR),
        .iMEMDATA(iMEMDATA), .iMEMVALID(iMEMVALID)
    );

    initial begin
        iCLK = 0;
        forever #5 iCLK = ~iCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return 32'hA000_0000 + ((a - 32'h100) >> 2);
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // backing memory: answers each beat after MW wait cycles unless held off
    initial begin
        int cnt;
        cnt = 0;
        iMEMVALID = 0;
        iMEMDATA = 0;
        forever begin
            @(posedge iCLK);
            #4;
            if (oMEMREQ && !mem_hold && cnt >= MW) begin
                iMEMVALID = 1;
                iMEMDATA = mem_data(oMEMADDR);
                cnt = 0;
            end else begin
                iMEMVALID = spurious;
                iMEMDATA = 32'hDEAD_BEEF;
                cnt = (oMEMREQ && !mem_hold) ? cnt + 1 : 0;
            end
        end
    end

    // monitor: compares delivered words and accepted memory beats against the queues
    initial begin
        fire_q = 0;
        forever begin
            @(negedge iCLK);
            if (fire_q) begin
                checks++;
                if (exp_data.size() == 0) begin
                    failures++;
                    $display("FAIL data_unexpected got=%h", oINSTDATA);
                end else begin
                    mon_e = exp_data.pop_front();
                    if (oINSTDATA !== mon_e) begin
                        failures++;
                        $display("FAIL data got=%h exp=%h", oINSTDATA, mon_e);
                    end
                end
            end
            fire_q = iREQ & ~oStallI & iRSTn;
            if (oMEMREQ && iMEMVALID) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    failures++;
                    $display("FAIL memaddr_unexpected got=%h", oMEMADDR);
                end else begin
                    mon_e = exp_addr.pop_front();
                    if (oMEMADDR !== mon_e) begin
                        failures++;
                        $display("FAIL memaddr got=%h exp=%h", oMEMADDR, mon_e);
                    end
                end
            end
        end
    end

    // one held fetch: queues its refills and word, optionally holds memory or flushes on beat 1
    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int refills, input int hold, input bit flush2);
        int n = 0;
        int held = 0;
        bit fl_done = 0;
        for (int r = 0; r < refills; r++)
            for (int k = 0; k < 4; k++) exp_addr.push_back((a & ~32'hF) | (k << 2));
        exp_data.push_back(d);
        iREQ = 1;
        iINSTADDR = a;
        #1;
        if (refills == 0) begin
            chk("hit_stall", {31'b0, oStallI}, 0);
            chk("hit_memreq", {31'b0, oMEMREQ}, 0);
        end
        while (oStallI && n < 200) begin
            if (hold > 0 && mem_hold && oMEMREQ) begin
                if (held == hold) mem_hold = 0;
                else begin
                    chk("bp_addr", oMEMADDR, a & ~32'hF);
                    held++;
                end
            end
            if (oMEMREQ && oMEMADDR[3:2] == 2'd2) fl_done = 1;
            iFLUSH = flush2 && !fl_done && oMEMREQ && oMEMADDR[3:2] == 2'd1;
            n++;
            tick();
            #1;
        end
        iFLUSH = 0;
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL fetch_timeout addr=%h stalled %0d cycles", a, n);
        end
        chk("stall_cycles", n, refills * (2 + 4 * (MW + 1)) + hold);
        tick();
        iREQ = 0;
    endtask

    initial begin
        int w;
        iRSTn = 0;
        iREQ = 0;
        iFLUSH = 0;
        iINSTADDR = 0;
        repeat (3) tick();
        chk("rst_data", oINSTDATA, 0);
        chk("rst_memreq", {31'b0, oMEMREQ}, 0);
        chk("rst_memaddr", oMEMADDR, 0);
        chk("rst_stall", {31'b0, oStallI}, 0);
        iRSTn = 1;
        tick();
        // cold miss, hits in the same line, conflict eviction and re-miss
        fetch(32'h104, 32'hA000_0001, 1, 0, 0);
        fetch(32'h10C, 32'hA000_0003, 0, 0, 0);
        fetch(32'h100, 32'hA000_0000, 0, 0, 0);
        fetch(32'h204, 32'hA000_0041, 1, 0, 0);
        fetch(32'h104, 32'hA000_0001, 1, 0, 0);
        repeat (3) tick();
        chk("hold_data", oINSTDATA, 32'hA000_0001);
        // flush while idle
        fetch(32'h204, 32'hA000_0041, 1, 0, 0);
        fetch(32'h200, 32'hA000_0040, 0, 0, 0);
        iFLUSH = 1;
        tick();
        iFLUSH = 0;
        fetch(32'h200, 32'hA000_0040, 1, 0, 0);
        // flush during beat 1: refill completes, line is dropped, held fetch refills again
        fetch(32'h304, 32'hA000_0081, 2, 0, 1);
        fetch(32'h304, 32'hA000_0081, 0, 0, 0);
        // memory backpressure, then a spurious valid while idle
        mem_hold = 1;
        fetch(32'h404, 32'hA000_00C1, 1, 10, 0);
        spurious = 1;
        repeat (3) tick();
        chk("spur_memreq", {31'b0, oMEMREQ}, 0);
        chk("spur_stall", {31'b0, oStallI}, 0);
        spurious = 0;
        tick();
        fetch(32'h404, 32'hA000_00C1, 0, 0, 0);
        // reset once beat 0 has been accepted
        exp_addr.push_back(32'h500);
        iREQ = 1;
        iINSTADDR = 32'h504;
        w = 0;
        while (oMEMADDR !== 32'h504 && w < 50) begin
            tick();
            w++;
        end
        chk("abort_reached_beat1", oMEMADDR, 32'h504);
        iRSTn = 0;
        tick();
        chk("abort_memreq", {31'b0, oMEMREQ}, 0);
        chk("abort_memaddr", oMEMADDR, 0);
        chk("abort_data", oINSTDATA, 0);
        chk("abort_stall_req", {31'b0, oStallI}, 1);
        iRSTn = 1;
        iREQ = 0;
        #1;
        chk("abort_stall_noreq", {31'b0, oStallI}, 0);
        fetch(32'h504, 32'hA000_0101, 1, 0, 0);
        repeat (2) tick();
        chk("data_q_empty", exp_data.size(), 0);
        chk("addr_q_empty", exp_addr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
